// File: rtl/column_config_loader_pkg.sv
// Shared constants and FSM state type for the column configuration loader.
// Optional checksum states exist only when COLUMN_CONFIG_CHECKSUM_EN is defined.
package column_config_loader_pkg;

  localparam int TILES          = 8;
  localparam int TILE_BITS      = 524;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_TILE = (TILE_BITS + WORD_W - 1) / WORD_W;
  localparam int TOTAL_WORDS    = TILES * WORDS_PER_TILE;
  localparam int CONFIG_W       = TILES * TILE_BITS;
  // Bits of the final word of each tile that actually land in config_out.
  localparam int LAST_WORD_BITS = TILE_BITS - (WORDS_PER_TILE - 1) * WORD_W;
  localparam int TILE_IDX_W     = $clog2(TILES);
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_TILE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
`ifdef COLUMN_CONFIG_CHECKSUM_EN
    , S_CHECK,
    S_ERROR
`endif
  } state_t;

endpackage

// File: rtl/column_config_word_counter.sv
// Tile/word position counter for the column configuration stream.
// word_idx wraps after the last word of a tile and advances tile_idx.
module column_config_word_counter
  import column_config_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [TILE_IDX_W-1:0] tile_idx,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic                  last_word
);

  logic [TILE_IDX_W-1:0] tile_idx_reg;
  logic [WORD_IDX_W-1:0] word_idx_reg;

  // Position register: cleared at load start, stepped on every accepted word.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      tile_idx_reg <= '0;
      word_idx_reg <= '0;
    end else if (clear) begin
      tile_idx_reg <= '0;
      word_idx_reg <= '0;
    end else if (advance) begin
      if (word_idx_reg == WORD_IDX_W'(WORDS_PER_TILE - 1)) begin
        word_idx_reg <= '0;
        if (tile_idx_reg == TILE_IDX_W'(TILES - 1)) begin
          tile_idx_reg <= '0;
        end else begin
          tile_idx_reg <= tile_idx_reg + 1'b1;
        end
      end else begin
        word_idx_reg <= word_idx_reg + 1'b1;
      end
    end
  end

  assign tile_idx  = tile_idx_reg;
  assign word_idx  = word_idx_reg;
  assign last_word = (word_idx_reg == WORD_IDX_W'(WORDS_PER_TILE - 1));

endmodule

// File: rtl/column_config_loader.sv
// Loads one column's configuration image from a 32-bit word stream and holds
// the column fabric in reset until the full image is in place.
// Optional checksum word after the image: define COLUMN_CONFIG_CHECKSUM_EN.
module column_config_loader
  import column_config_loader_pkg::*;
(
  input  logic                clock,
  input  logic                nreset,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CONFIG_W-1:0] config_out,
  output logic                config_valid,
  output logic                busy,
  output logic                error,
  output logic                fabric_nreset
);

  state_t                state_reg, state_next;
  logic                  load_start;
  logic                  word_accept;
  logic                  last_image;
  logic                  fabric_nreset_reg;
  logic [TILE_IDX_W-1:0] tile_idx;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  last_word;
  logic [TILES-1:0]          tile_sel;
  logic [WORDS_PER_TILE-1:0] word_sel;
  logic [CONFIG_W-1:0]   config_reg, config_next;

  column_config_word_counter u_counter (
    .clock     (clock),
    .nreset    (nreset),
    .clear     (load_start),
    .advance   (word_accept),
    .tile_idx  (tile_idx),
    .word_idx  (word_idx),
    .last_word (last_word)
  );

  assign last_image = last_word && tile_sel[TILES-1];

`ifdef COLUMN_CONFIG_CHECKSUM_EN
  logic [WORD_W-1:0] csum_reg;

  // Running XOR of every full data word, restarted with each load.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      csum_reg <= '0;
    end else if (load_start) begin
      csum_reg <= '0;
    end else if (word_accept) begin
      csum_reg <= csum_reg ^ cfg_data;
    end
  end

  assign error = (state_reg == S_ERROR);
`else
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; start is only honoured outside a load.
  always_comb begin
    state_next   = state_reg;
    cfg_ready    = 1'b0;
    busy         = 1'b0;
    config_valid = 1'b0;
    load_start   = 1'b0;
    word_accept  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_valid) begin
          word_accept = 1'b1;
          if (last_image) begin
`ifdef COLUMN_CONFIG_CHECKSUM_EN
            state_next = S_CHECK;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        config_valid = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = S_LOAD;
        end
      end
`ifdef COLUMN_CONFIG_CHECKSUM_EN
      S_CHECK: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_valid) begin
          state_next = (cfg_data == csum_reg) ? S_DONE : S_ERROR;
        end
      end
      S_ERROR: begin
        if (start) begin
          load_start = 1'b1;
          state_next = S_LOAD;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // One-hot decode of the current tile and word position.
  for (genvar gi = 0; gi < TILES; gi++) begin : g_tile_sel
    assign tile_sel[gi] = (tile_idx == TILE_IDX_W'(gi));
  end
  for (genvar gi = 0; gi < WORDS_PER_TILE; gi++) begin : g_word_sel
    assign word_sel[gi] = (word_idx == WORD_IDX_W'(gi));
  end

  // Per-slice write enables; the final word of each tile is truncated so its
  // upper bits never spill into the next tile.
  for (genvar gi = 0; gi < TILES; gi++) begin : g_tile_wr
    for (genvar gk = 0; gk < WORDS_PER_TILE; gk++) begin : g_word_wr
      localparam int LO = gi * TILE_BITS + gk * WORD_W;
      localparam int N  = (gk == WORDS_PER_TILE - 1) ? LAST_WORD_BITS : WORD_W;
      assign config_next[LO +: N] = (word_accept && tile_sel[gi] && word_sel[gk])
                                    ? cfg_data[N-1:0] : config_reg[LO +: N];
    end
  end

  // Config image register; not cleared on start, only overwritten.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      config_reg <= '0;
    end else begin
      config_reg <= config_next;
    end
  end

  // Fabric reset releases one cycle after entering DONE and drops on the same
  // edge that leaves DONE.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      fabric_nreset_reg <= 1'b0;
    end else begin
      fabric_nreset_reg <= (state_reg == S_DONE) && (state_next == S_DONE);
    end
  end

  assign config_out    = config_reg;
  assign fabric_nreset = fabric_nreset_reg;

endmodule

// File: tb/tb_column_config_loader.sv
// Directed bench for column_config_loader: builds expected images from the
// word stream, queues them when a load is driven, and compares on completion.
// Define COLUMN_CONFIG_CHECKSUM_EN to exercise the checksum word.
module tb_column_config_loader;
  import column_config_loader_pkg::*;

  logic                clk = 1'b0;
  logic                nreset;
  logic                start;
  logic [WORD_W-1:0]   cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CONFIG_W-1:0] config_out;
  logic                config_valid;
  logic                busy;
  logic                error;
  logic                fabric_nreset;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [WORD_W-1:0]   img_words [TOTAL_WORDS];
  logic [CONFIG_W-1:0] exp_q [$];

  column_config_loader dut (
    .clock         (clk),
    .nreset        (nreset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .config_out    (config_out),
    .config_valid  (config_valid),
    .busy          (busy),
    .error         (error),
    .fabric_nreset (fabric_nreset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference image: word k of tile t fills bits t*TILE_BITS + k*WORD_W,
  // the last word of a tile contributes only LAST_WORD_BITS bits.
  function automatic logic [CONFIG_W-1:0] model_image();
    logic [CONFIG_W-1:0] img = '0;
    for (int i = 0; i < TOTAL_WORDS; i++) begin
      int t = i / WORDS_PER_TILE;
      int k = i % WORDS_PER_TILE;
      if (k < WORDS_PER_TILE - 1)
        img[t*TILE_BITS + k*WORD_W +: WORD_W] = img_words[i];
      else
        img[t*TILE_BITS + k*WORD_W +: LAST_WORD_BITS] = img_words[i][LAST_WORD_BITS-1:0];
    end
    return img;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < TOTAL_WORDS; i++) begin
      case (mode)
        0: img_words[i] = 32'(i);
        1: img_words[i] = (i % WORDS_PER_TILE == WORDS_PER_TILE - 1) ? 32'hFFFFF123 : $urandom;
        default: img_words[i] = 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0000;
      endcase
    end
  endtask

  task automatic chk_image(input string tag);
    logic [CONFIG_W-1:0] exp;
    n_asserts++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL %s: observed completion expected no pending image", tag);
    end else begin
      exp = exp_q.pop_front();
      assert (config_out === exp) else begin
        int j = 0;
        n_fails++;
        while (j < CONFIG_W / 32 - 1 && config_out[j*32 +: 32] === exp[j*32 +: 32]) j++;
        $error("FAIL %s: observed config_out[%0d*32+:32]=%h expected %h",
               tag, j, config_out[j*32 +: 32], exp[j*32 +: 32]);
      end
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_cfg_valid"}, 64'(config_valid), 64'd0);
    chk({tag, "_fabric"}, 64'(fabric_nreset), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  // Streams img_words; optional random gaps, optional start pulse presented
  // with word start_at, optional corrupted checksum word.
  task automatic load_image(input string tag, input bit gaps, input int start_at,
                            input bit bad_csum);
    int i = 0;
    int cycles = 0;
    bit pulsed = 1'b0;
    logic [WORD_W-1:0] csum = '0;
    if (!bad_csum) exp_q.push_back(model_image());
    while (i < TOTAL_WORDS && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      start = (!pulsed && i == start_at);
      if (start) pulsed = 1'b1;
      chk({tag, "_ready"}, 64'(cfg_ready), 64'd1);
      if (gaps && $urandom_range(0, 1) == 0) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = img_words[i];
        csum      = csum ^ img_words[i];
        if (i == TOTAL_WORDS - 1) begin
          chk({tag, "_valid_before_last"}, 64'(config_valid), 64'd0);
          chk({tag, "_fabric_before_last"}, 64'(fabric_nreset), 64'd0);
        end
        @(posedge clk);
        i++;
      end
    end
    chk({tag, "_words_sent"}, 64'(i), 64'(TOTAL_WORDS));
`ifdef COLUMN_CONFIG_CHECKSUM_EN
    @(negedge clk);
    start     = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = csum ^ {31'd0, bad_csum};
    chk({tag, "_csum_ready"}, 64'(cfg_ready), 64'd1);
    @(posedge clk);
`endif
    @(negedge clk);
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (bad_csum) begin
      chk({tag, "_error"}, 64'(error), 64'd1);
      chk({tag, "_err_cfg_valid"}, 64'(config_valid), 64'd0);
      chk({tag, "_err_ready"}, 64'(cfg_ready), 64'd0);
      chk({tag, "_err_fabric"}, 64'(fabric_nreset), 64'd0);
      @(negedge clk);
      chk({tag, "_err_fabric_hold"}, 64'(fabric_nreset), 64'd0);
    end else begin
      chk({tag, "_cfg_valid"}, 64'(config_valid), 64'd1);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      chk({tag, "_fabric_lag"}, 64'(fabric_nreset), 64'd0);
      chk_image({tag, "_image"});
      @(negedge clk);
      chk({tag, "_fabric_rise"}, 64'(fabric_nreset), 64'd1);
    end
  endtask

  initial begin
    nreset    = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_config_out", 64'(config_out == '0), 64'd1);
    chk("rst_cfg_valid", 64'(config_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_fabric", 64'(fabric_nreset), 64'd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(cfg_ready), 64'd0);

    // Back-to-back counting image.
    fill(0);
    do_start("s1");
    load_image("b2b", 1'b0, -1, 1'b0);
    chk("b2b_t0_w0", 64'(config_out[31:0]), 64'h0);
    chk("b2b_t0_last", 64'(config_out[523:512]), 64'h010);
    chk("b2b_t1_w0", 64'(config_out[TILE_BITS +: 32]), 64'h11);

    // Restart from DONE, same image with random valid gaps.
    do_start("s2");
    load_image("gaps", 1'b1, -1, 1'b0);

    // Last-word truncation with a 0xFFFFF123 tail word.
    fill(1);
    do_start("s3");
    load_image("trunc", 1'b1, -1, 1'b0);
    for (int t = 0; t < TILES; t++) begin
      chk($sformatf("trunc_tail_t%0d", t), 64'(config_out[t*TILE_BITS + 512 +: 12]), 64'h123);
      if (t < TILES - 1)
        chk($sformatf("trunc_next_bit0_t%0d", t + 1), 64'(config_out[(t+1)*TILE_BITS]),
            64'(img_words[(t+1)*WORDS_PER_TILE][0]));
    end

    // Asynchronous reset after 70 words of a load.
    fill(2);
    do_start("s4");
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = img_words[i];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    nreset    = 1'b0;
    #1;
    chk("mid_rst_cfg_valid", 64'(config_valid), 64'd0);
    chk("mid_rst_fabric", 64'(fabric_nreset), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_config_out", 64'(config_out == '0), 64'd1);
    @(negedge clk);
    nreset = 1'b1;
    do_start("s5");
    load_image("after_rst", 1'b0, -1, 1'b0);

    // start pulse alongside word 40 must not restart the load.
    fill(0);
    do_start("s6");
    load_image("start_in_load", 1'b0, 40, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_fabric_drop", 64'(fabric_nreset), 64'd0);
    chk("restart_cfg_valid", 64'(config_valid), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    load_image("restart_load", 1'b0, -1, 1'b0);

`ifdef COLUMN_CONFIG_CHECKSUM_EN
    fill(2);
    do_start("s7");
    load_image("bad_csum", 1'b1, -1, 1'b1);
    do_start("s8");
    chk("err_cleared", 64'(error), 64'd0);
    load_image("good_csum", 1'b0, -1, 1'b0);
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
